// File: rtl/bram_copy_pkg.sv
// Shared frame-copy definitions: state encoding and the default frame geometry
// used by the camera frame buffer (320x240 words of 12-bit pixels).
package bram_copy_pkg;

  localparam int FRAME_ADDR_W = 17;
  localparam int FRAME_DATA_W = 12;
  localparam int FRAME_DEPTH  = 76800;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-deep {valid, addr} delay line that tracks source BRAM read latency.
// flush drops every in-flight valid on the next clock edge.
module rd_lat_pipe
  import bram_copy_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = FRAME_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              tap_valid,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              any_valid
);

  logic [RD_LAT-1:0] valid_r;
  logic [ADDR_W-1:0] addr_r [RD_LAT];

  // Shift valids and addresses one stage per cycle; flush clears only the valids
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_r[i] <= '0;
      end
    end else begin
      if (flush) begin
        valid_r <= '0;
      end else begin
        for (int i = RD_LAT - 1; i > 0; i--) begin
          valid_r[i] <= valid_r[i-1];
        end
        valid_r[0] <= in_valid;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        addr_r[i] <= addr_r[i-1];
      end
      addr_r[0] <= in_addr;
    end
  end

  assign tap_valid = valid_r[RD_LAT-1];
  assign tap_addr  = addr_r[RD_LAT-1];
  assign any_valid = |valid_r;

endmodule

// File: rtl/bram_copy_ctrl.sv
// Bounded frame copy from a source BRAM to a destination BRAM with pause/abort.
// Optional BRAM_COPY_CHECKSUM_EN adds a running sum of every written word.
module bram_copy_ctrl
  import bram_copy_pkg::*;
#(
  parameter int ADDR_W = FRAME_ADDR_W,
  parameter int DATA_W = FRAME_DATA_W,
  parameter int DEPTH  = FRAME_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_dout,
  output logic              dst_we,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_din,
  output logic [ADDR_W:0]   words_done
`ifdef BRAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W+7:0] checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r, state_s;
  logic              issue_s, accept_s, abort_s, wr_s;
  logic [ADDR_W-1:0] iss_addr_s;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic              busy_r, done_r, src_en_r, dst_we_r;
  logic [ADDR_W-1:0] src_addr_r, dst_addr_r;
  logic [DATA_W-1:0] dst_din_r;
  logic [ADDR_W:0]   words_done_r;
  logic              tap_valid_s, any_valid_s;
  logic [ADDR_W-1:0] tap_addr_s;

  // Next-state and read-issue decision; the accepting IDLE cycle already issues address 0
  always_comb begin
    state_s    = state_r;
    issue_s    = 1'b0;
    accept_s   = 1'b0;
    abort_s    = 1'b0;
    iss_addr_s = rd_ptr_r;
    case (state_r)
      S_IDLE: begin
        iss_addr_s = '0;
        if (start && !abort) begin
          accept_s = 1'b1;
          issue_s  = !pause;
          if (!pause && (LAST_ADDR == ADDR_W'(0))) begin
            state_s = S_DRAIN;
          end else begin
            state_s = S_RUN;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          abort_s = 1'b1;
          state_s = S_IDLE;
        end else if (!pause) begin
          issue_s = 1'b1;
          if (rd_ptr_r == LAST_ADDR) begin
            state_s = S_DRAIN;
          end else begin
            state_s = S_RUN;
          end
        end else begin
          state_s = S_RUN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          abort_s = 1'b1;
          state_s = S_IDLE;
        end else if (!src_en_r && !any_valid_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  assign wr_s = tap_valid_s && !abort_s;

  rd_lat_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .n_rst     (n_rst),
    .flush     (abort_s),
    .in_valid  (src_en_r),
    .in_addr   (src_addr_r),
    .tap_valid (tap_valid_s),
    .tap_addr  (tap_addr_s),
    .any_valid (any_valid_s)
  );

  // State, read pointer, registered outputs and the write counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= S_IDLE;
      rd_ptr_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      src_en_r     <= 1'b0;
      src_addr_r   <= '0;
      dst_we_r     <= 1'b0;
      dst_addr_r   <= '0;
      dst_din_r    <= '0;
      words_done_r <= '0;
    end else begin
      state_r  <= state_s;
      busy_r   <= (state_s == S_RUN) || (state_s == S_DRAIN);
      done_r   <= (state_s == S_DONE);
      src_en_r <= issue_s;
      if (issue_s) begin
        src_addr_r <= iss_addr_s;
        // saturate at the last address so the pointer never wraps within a copy
        rd_ptr_r   <= (iss_addr_s == LAST_ADDR) ? iss_addr_s : iss_addr_s + ADDR_W'(1);
      end else if (accept_s) begin
        rd_ptr_r <= '0;
      end
      dst_we_r <= wr_s;
      if (wr_s) begin
        dst_addr_r <= tap_addr_s;
        dst_din_r  <= src_dout;
      end
      if (accept_s) begin
        words_done_r <= '0;
      end else if (wr_s) begin
        words_done_r <= words_done_r + (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef BRAM_COPY_CHECKSUM_EN
  logic [DATA_W+7:0] checksum_r;

  // Running modulo sum of the words written in the current/last copy
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      checksum_r <= '0;
    end else if (accept_s) begin
      checksum_r <= '0;
    end else if (wr_s) begin
      checksum_r <= checksum_r + {8'd0, src_dout};
    end
  end

  assign checksum = checksum_r;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign src_en     = src_en_r;
  assign src_addr   = src_addr_r;
  assign dst_we     = dst_we_r;
  assign dst_addr   = dst_addr_r;
  assign dst_din    = dst_din_r;
  assign words_done = words_done_r;

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// Scoreboard bench for bram_copy_ctrl (DEPTH=8, source mem[i]=i+0x100).
// Define TB_RD_LAT2 for the RD_LAT=2 build; BRAM_COPY_CHECKSUM_EN enables checksum checks.
module tb_bram_copy_ctrl;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;
`ifdef TB_RD_LAT2
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic              clk   = 1'b0;
  logic              n_rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              pause = 1'b0;
  logic              busy, done, src_en, dst_we;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [DATA_W-1:0] src_dout, dst_din;
  logic [ADDR_W:0]   words_done;
`ifdef BRAM_COPY_CHECKSUM_EN
  logic [DATA_W+7:0] checksum;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   epoch  = 0;
  ev_t  exp_rd_q[$];
  ev_t  exp_wr_q[$];
  ev_t  exp_done_q[$];
  bit   exp_busy[int];
  ev_t  ev;
  logic [DATA_W-1:0] src_mem [256];
  logic [DATA_W-1:0] dst_mem [DEPTH];
  int                dst_ep  [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  bram_copy_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .pause      (pause),
    .busy       (busy),
    .done       (done),
    .src_en     (src_en),
    .src_addr   (src_addr),
    .src_dout   (src_dout),
    .dst_we     (dst_we),
    .dst_addr   (dst_addr),
    .dst_din    (dst_din),
    .words_done (words_done)
`ifdef BRAM_COPY_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source BRAM: data appears RD_LAT cycles after src_en
  always @(posedge clk) begin
    if (src_en) rd_pipe[0] <= src_mem[src_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign src_dout = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Index of the last start-relative cycle whose sampled pause lets a read go out
  function automatic int last_issue(input logic [63:0] pp);
    int issued = 0;
    int c = 0;
    int l = 0;
    while (issued < DEPTH) begin
      if (c >= 64 || !pp[c]) begin
        issued++;
        l = c;
      end
      c++;
    end
    return l;
  endfunction

  function automatic int done_ofs(input logic [63:0] pp);
    return last_issue(pp) + 3 + RD_LAT;
  endfunction

  // Reference model: read at c+1 for each unpaused cycle c, write RD_LAT+1 later,
  // done one cycle after the last write; abort at offset ab truncates everything after it
  task automatic plan_copy(input int s, input logic [63:0] pp, input int ab,
                           output int dofs, output int nwr);
    int issued = 0;
    int c = 0;
    int r, w, lim;
    int csum = 0;
    dofs = done_ofs(pp);
    lim  = (ab >= 0) ? s + ab : s + dofs - 1;
    nwr  = 0;
    while (issued < DEPTH) begin
      if (c >= 64 || !pp[c]) begin
        r = s + c + 1;
        w = r + RD_LAT + 1;
        if (r <= lim) exp_rd_q.push_back('{r, issued, 0});
        if (w <= lim) begin
          exp_wr_q.push_back('{w, issued, 'h100 + issued});
          csum += 'h100 + issued;
          nwr++;
        end
        issued++;
      end
      c++;
    end
    for (int cy = s + 1; cy <= lim; cy++) exp_busy[cy] = 1'b1;
    if (ab < 0) exp_done_q.push_back('{s + dofs, DEPTH, csum % (1 << (DATA_W + 8))});
  endtask

  task automatic run_copy(input logic [63:0] pp, input int ab);
    int s, dofs, nwr, last;
    @(posedge clk); #1;
    s = cyc;
    epoch++;
    plan_copy(s, pp, ab, dofs, nwr);
    last = (ab >= 0) ? ab : dofs;
    for (int o = 0; o <= last; o++) begin
      start = (o == 0);
      pause = (o < 64) ? pp[o] : 1'b0;
      abort = (o == ab);
      @(posedge clk); #1;
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (ab >= 0) begin
      chk("words_done_after_abort", words_done, nwr);
    end else begin
      chk("words_done_hold", words_done, DEPTH);
      for (int i = 0; i < DEPTH; i++)
        chk("dst_mem", {dst_ep[i] == epoch, dst_mem[i]}, {1'b1, DATA_W'(32'h100 + i)});
    end
  endtask

  // Scoreboard monitor: each DUT output event is matched against the front of its queue
  always @(negedge clk) begin
    if (n_rst) begin
      if (src_en) begin
        if (exp_rd_q.size() == 0) chk("src_en_unexpected", src_en, 0);
        else begin
          ev = exp_rd_q.pop_front();
          chk("src_en_cycle", cyc, ev.cyc);
          chk("src_addr", src_addr, ev.addr);
        end
      end
      while (exp_rd_q.size() != 0 && exp_rd_q[0].cyc < cyc) begin
        ev = exp_rd_q.pop_front();
        chk("src_en_missing", cyc, ev.cyc);
      end
      if (dst_we) begin
        dst_mem[dst_addr[2:0]] = dst_din;
        dst_ep[dst_addr[2:0]]  = epoch;
        if (exp_wr_q.size() == 0) chk("dst_we_unexpected", dst_we, 0);
        else begin
          ev = exp_wr_q.pop_front();
          chk("dst_we_cycle", cyc, ev.cyc);
          chk("dst_addr", dst_addr, ev.addr);
          chk("dst_din", dst_din, ev.data);
        end
      end
      while (exp_wr_q.size() != 0 && exp_wr_q[0].cyc < cyc) begin
        ev = exp_wr_q.pop_front();
        chk("dst_we_missing", cyc, ev.cyc);
      end
      if (done) begin
        if (exp_done_q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          ev = exp_done_q.pop_front();
          chk("done_cycle", cyc, ev.cyc);
          chk("words_done_at_done", words_done, ev.addr);
`ifdef BRAM_COPY_CHECKSUM_EN
          chk("checksum_at_done", checksum, ev.data);
`endif
        end
      end
      while (exp_done_q.size() != 0 && exp_done_q[0].cyc < cyc) begin
        ev = exp_done_q.pop_front();
        chk("done_missing", cyc, ev.cyc);
      end
      chk("busy", busy, exp_busy.exists(cyc));
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_src_en"}, src_en, 0);
    chk({tag, "_src_addr"}, src_addr, 0);
    chk({tag, "_dst_we"}, dst_we, 0);
    chk({tag, "_dst_addr"}, dst_addr, 0);
    chk({tag, "_dst_din"}, dst_din, 0);
    chk({tag, "_words_done"}, words_done, 0);
`ifdef BRAM_COPY_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    int s, d1, d2, n1, n2, ab;
    logic [63:0] pp;
    for (int i = 0; i < 256; i++) src_mem[i] = DATA_W'(32'h100 + i);
    for (int i = 0; i < DEPTH; i++) dst_ep[i] = 0;

    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    n_rst = 1'b1;

    run_copy(64'h0, -1);
    run_copy(64'h38, -1);
    run_copy(64'h0, 4);
    run_copy(64'h0, -1);

    // start held high across a whole copy: one copy per IDLE entry
    @(posedge clk); #1;
    s = cyc;
    plan_copy(s, 64'h0, -1, d1, n1);
    plan_copy(s + d1 + 1, 64'h0, -1, d2, n2);
    start = 1'b1;
    repeat (d1 + 2) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (d2 + 2) @(posedge clk);
    #1;
    chk("held_words_done", words_done, n2);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_abort_idle_busy", busy, 0);
    chk("start_abort_idle_words", words_done, n2);

    for (int k = 0; k < 8; k++) begin
      pp = {$urandom, $urandom} & {$urandom, $urandom} & ~64'h1;
      ab = ($urandom_range(1, 0) == 1) ? $urandom_range(done_ofs(pp) - 1, 1) : -1;
      run_copy(pp, ab);
    end

    // reset in the middle of a copy
    @(posedge clk); #1;
    s = cyc;
    epoch++;
    plan_copy(s, 64'h0, -1, d1, n1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_done_q.delete();
    exp_busy.delete();
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    run_copy(64'h0, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("pending_reads", exp_rd_q.size(), 0);
    chk("pending_writes", exp_wr_q.size(), 0);
    chk("pending_done", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_copy_ctrl.md
Name: bram_copy_ctrl

Overview:
- Sequences one full-frame copy from a source BRAM (camera frame buffer) to a destination BRAM (display/processing buffer) on request.
- Generates source read addresses, tracks BRAM read latency with a valid/address pipeline, and issues matching destination writes.
- Supports pause (source port contention) and abort.
- Supersedes free-running copy enables: the copy is bounded, counted and reports completion.

Parameters:
- ADDR_W, 17, width of source/destination word address
- DATA_W, 12, pixel word width
- DEPTH, 76800, number of words copied per frame (320x240); must be <= 2**ADDR_W
- RD_LAT, 1, source BRAM read latency in cycles (1 or 2)

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  request one frame copy; sampled in IDLE only
- abort  in  1  cancel copy in progress
- pause  in  1  suppress new source reads this cycle
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse after last destination write
- src_en  out  1  source BRAM read enable
- src_addr  out  ADDR_W  source read address
- src_dout  in  DATA_W  source read data, valid RD_LAT cycles after src_en
- dst_we  out  1  destination write enable
- dst_addr  out  ADDR_W  destination write address
- dst_din  out  DATA_W  destination write data
- words_done  out  ADDR_W+1  count of destination writes in current/last copy

Behaviour:
- Clock/reset: single clock clk; reset n_rst is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; read pointer, pipeline and counter 0.
- All outputs are registered.
- States:
  - IDLE: start=1 and abort=0 -> RUN. Read pointer and words_done clear; busy=1 the next cycle.
  - RUN: each cycle with pause=0, src_en=1, src_addr=rd_ptr, rd_ptr+1. With pause=1, src_en=0 and rd_ptr holds. After issuing address DEPTH-1 -> DRAIN.
  - DRAIN: no new reads; wait until the pipeline is empty and the final dst_we has been issued -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- Pipeline:
  - RD_LAT-deep shift register of {src_en, src_addr}.
  - When the tap valid=1: next cycle dst_we=1, dst_addr=tapped address, dst_din=src_dout captured at the tap.
  - Latency: source read (src_en high) to dst_we high is RD_LAT+1 cycles.
  - Start sampled at cycle 0 -> first src_en at cycle 1 -> first dst_we at cycle 2+RD_LAT.
- Pause: affects new reads only. In-flight reads still complete and write. Pause in DRAIN has no effect.
- Counting: words_done increments on every dst_we and equals DEPTH at done. It holds its value in IDLE until the next start.
- Boundaries:
  - start while busy is ignored.
  - start and abort in the same IDLE cycle: abort wins, stay IDLE.
  - abort in RUN/DRAIN: next cycle src_en=0, pipeline valids cleared, no further dst_we, busy=0, no done pulse, state IDLE. words_done keeps its partial count.
  - abort in DONE: done still pulses; abort has no effect.
  - rd_ptr never exceeds DEPTH-1; no wrap within a copy.
  - DEPTH=1 is legal: RUN lasts one issuing cycle.
  - Reset asserted mid-copy: everything returns to reset values immediately.

Optional Feature:
- Macro: BRAM_COPY_CHECKSUM_EN.
- Enabled:
  - Adds output checksum (DATA_W+8 bits): running unsigned sum of every dst_din written, modulo 2**(DATA_W+8).
  - Clears on accepted start; final value is valid when done pulses; holds until the next start.
  - Abort leaves the partial sum.
- Disabled: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package bram_copy_pkg:
  - state encoding localparams ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE
  - default DEPTH/ADDR_W/DATA_W frame constants shared with the camera frame buffer
- Sub-module rd_lat_pipe: RD_LAT-deep {valid, addr} delay line with synchronous flush input used by abort.
- FSM, read pointer and counter stay in the top.

Test Plan (bench uses DEPTH=8, RD_LAT=1, source BRAM model with mem[i]=i+0x100):
- Reset then start pulse at cycle 0 -> src_en at cycles 1..8 with addr 0..7; dst_we at cycles 3..10 with dst_addr 0..7, dst_din 0x100..0x107; done at cycle 11; busy high cycles 1..10; words_done=8.
- pause high for 3 cycles mid-RUN -> src_en gap of 3 cycles; all 8 words written exactly once in order; done delayed by 3 cycles; destination contents match the source.
- abort after the 4th src_en -> no dst_we after the in-flight flush; busy=0 next cycle; no done pulse; words_done<=3; a new start afterwards completes a full copy of 8.
- start held high continuously through and after the copy -> exactly one copy per IDLE entry; start ignored while busy; start and abort together in IDLE -> stays IDLE.
- RD_LAT=2 rebuild, same stimulus as the first test -> first dst_we at cycle 4, done at cycle 12, data correct.
- With BRAM_COPY_CHECKSUM_EN, first-test stimulus -> checksum=0x81C (sum 0x100..0x107) at done.
